// File: rtl/uart_tx_arbiter.sv
// Shares one xmit UART transmitter between NREQ byte requesters: picks a winner, pulses sendchar,
// follows the busy handshake and enforces an idle gap. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 255,
  parameter int IW           = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic [IW-1:0]     grant_id,
  output logic              active,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: req_valid/req_data are held by the requester until req_ready pulses for one
  // cycle; the byte is captured on that edge, and valid still high afterwards is a new byte.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);

  state_e            state_q;
  logic [GW-1:0]     gap_q;
  logic [TW-1:0]     to_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [7:0]        tx_data_q;
  logic              tx_send_q;
  logic [IW-1:0]     grant_id_q;
  logic              err_q;

  logic              any_valid;
  logic [IW-1:0]     win_d;
  logic [7:0]        win_byte_d;
  logic [NREQ-1:0]   win_oh_d;
  logic [7:0]        req_bytes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  assign any_valid = |req_valid;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[IW'(i)]) win_d = IW'(i);
    end
  end
`else
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [IW:0]   rr_sum;

  // Search starts at rr_q; scanning offsets downwards leaves the nearest hit in win_d.
  always_comb begin
    win_d  = '0;
    rr_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NREQ)) rr_sum = rr_sum - (IW+1)'(NREQ);
      if (req_valid[rr_sum[IW-1:0]]) win_d = rr_sum[IW-1:0];
    end
  end

  always_comb begin
    rr_d = (win_d == IW'(NREQ - 1)) ? '0 : win_d + 1'b1;
  end
`endif

  assign win_byte_d = req_bytes[win_d];
  assign win_oh_d   = NREQ'(1) << win_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      to_q        <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      grant_id_q  <= '0;
      err_q       <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      tx_send_q   <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          // A busy transmitter here means xmit is still draining a byte from before a reset.
          if (!tx_busy && any_valid) begin
            tx_data_q   <= win_byte_d;
            grant_id_q  <= win_d;
            req_ready_q <= win_oh_d;
            tx_send_q   <= 1'b1;
            to_q        <= '0;
            state_q     <= WAIT_BUSY;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (to_q == TO_LAST) begin
            err_q <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= GAP;
            end
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign grant_id  = grant_id_q;
  assign err       = err_q;
  assign active    = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level reference model and an xmit busy model.
module tb_uart_tx_arbiter;
  localparam int G  = 16;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err;
  logic [1:0]  dbg_state;

  logic [3:0]  r0_valid;
  logic [31:0] r0_data;
  logic [3:0]  r0_ready;
  logic [7:0]  t0_data;
  logic        t0_send;
  logic        busy0;
  logic [1:0]  g0_id;
  logic        a0;
  logic        e0;
  logic [1:0]  s0;

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(G), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .err(err), .dbg_state(dbg_state)
  );

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(TO)) dut_nogap (
    .clk(clk), .reset(reset), .req_valid(r0_valid), .req_data(r0_data), .req_ready(r0_ready),
    .tx_data(t0_data), .tx_send(t0_send), .tx_busy(busy0), .grant_id(g0_id),
    .active(a0), .err(e0), .dbg_state(s0)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [3:0]  pend;
  logic [7:0]  bytes [4];
  int          rr_m;
  int          upd_mode;
  logic [7:0]  last_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference arbitration: first pending requester in search order.
  function automatic int pick(input logic [3:0] m, input int r);
    int w;
    w = -1;
    for (int k = 0; k < 4; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      int i = k;
`else
      int i = (r + k) % 4;
`endif
      if (w < 0 && m[i]) w = i;
    end
    return w;
  endfunction

  task automatic drive_reqs();
    req_valid = pend;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = bytes[i];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"},   32'(tx_data),   32'd0);
    check({tag, "_send"},   32'(tx_send),   32'd0);
    check({tag, "_ready"},  32'(req_ready), 32'd0);
    check({tag, "_gid"},    32'(grant_id),  32'd0);
    check({tag, "_active"}, 32'(active),    32'd0);
    check({tag, "_err"},    32'(err),       32'd0);
    check({tag, "_state"},  32'(dbg_state), 32'd0);
  endtask

  task automatic quiet(input logic exp_act);
    check("send_quiet",  32'(tx_send),   32'd0);
    check("ready_quiet", 32'(req_ready), 32'd0);
    check("active",      32'(active),    32'(exp_act));
    check("data_hold",   32'(tx_data),   32'(last_byte));
  endtask

  // Called right after the edge on which a grant is expected; then updates the requesters.
  task automatic check_grant();
    int w;
    w = pick(pend, rr_m);
    exp_q.push_back(bytes[w]);
    check("grant_ready",  32'(req_ready), 32'd1 << w);
    check("grant_send",   32'(tx_send),   32'd1);
    check("grant_data",   32'(tx_data),   32'(exp_q.pop_front()));
    check("grant_id",     32'(grant_id),  32'(w));
    check("grant_active", 32'(active),    32'd1);
    check("grant_err",    32'(err),       32'd0);
    last_byte = bytes[w];
    rr_m = (w + 1) % 4;
    if (upd_mode == 0) begin
      if ($urandom_range(0, 1) == 0) bytes[w] = 8'($urandom);
      else pend[w] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j != w) begin
          if (!pend[j] && $urandom_range(0, 2) == 0) begin
            pend[j]  = 1'b1;
            bytes[j] = 8'($urandom);
          end else if (pend[j] && $urandom_range(0, 9) == 0) begin
            pend[j] = 1'b0;
          end
        end
      end
      if (pend == 4'b0) begin
        int j;
        j = $urandom_range(0, 3);
        pend[j]  = 1'b1;
        bytes[j] = 8'($urandom);
      end
    end
    drive_reqs();
  endtask

  task automatic gap_tail();
    repeat (G - 1) begin
      tick(); quiet(1'b1); check("err_gap", 32'(err), 32'd0);
    end
    tick(); quiet(1'b0);
  endtask

  // mode 0: busy after d clocks for l clocks; mode 1: busy never rises.
  task automatic run_txn(input int mode, input int d, input int l);
    tick(); check_grant();
    if (mode == 1) begin
      repeat (TO - 1) begin
        tick(); quiet(1'b1); check("err_early", 32'(err), 32'd0);
      end
      tick(); quiet(1'b1); check("err_pulse", 32'(err), 32'd1);
      gap_tail();
    end else begin
      repeat (d) begin
        tick(); quiet(1'b1); check("err_wait_busy", 32'(err), 32'd0);
      end
      tx_busy = 1'b1;
      repeat (l) begin
        tick(); quiet(1'b1); check("err_wait_done", 32'(err), 32'd0);
      end
      tx_busy = 1'b0;
      tick(); quiet(1'b1); check("err_gap", 32'(err), 32'd0);
      gap_tail();
    end
  endtask

  task automatic reload(input logic [3:0] m, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    pend = 4'b0;
    drive_reqs();
    tick(); quiet(1'b0);
    pend = m;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    drive_reqs();
  endtask

  initial begin
    reset = 1'b1; tx_busy = 1'b0; req_valid = '0; req_data = '0;
    busy0 = 1'b0; r0_valid = '0; r0_data = '0;
    pend = '0; rr_m = 0; upd_mode = 0; last_byte = '0;
    for (int i = 0; i < 4; i++) bytes[i] = '0;
    repeat (3) tick();
    check_reset("rst");

    // single requester, busy 2 clocks after send for 100 clocks
    pend = 4'b0100; bytes[2] = 8'h41; upd_mode = 1;
    drive_reqs();
    reset = 1'b0;
    run_txn(0, 1, 100);
    run_txn(0, 1, 100);

    // all four always valid
    reload(4'hf, 8'h30, 8'h31, 8'h32, 8'h33);
    repeat (8) run_txn(0, $urandom_range(0, 2), $urandom_range(1, 20));

    // busy stuck low, then busy rising exactly on the last allowed edge
    run_txn(1, 0, 0);
    run_txn(0, 1, 5);
    run_txn(0, TO - 1, 5);

    // reset while transmitter busy in WAIT_DONE
    tick(); check_grant();
    tx_busy = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 check_reset("rst_mid");
    tick();
    reset = 1'b0; rr_m = 0; last_byte = '0;
    repeat (4) begin
      tick(); quiet(1'b0);
    end
    tx_busy = 1'b0;
    run_txn(0, 1, 10);

    // random traffic
    reload(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    upd_mode = 0;
    repeat (30) begin
      if ($urandom_range(0, 9) == 0) run_txn(1, 0, 0);
      else run_txn(0, $urandom_range(0, 2), $urandom_range(1, 40));
    end
    pend = '0;
    drive_reqs();

    // zero-gap instance: requester 1 always valid
    r0_valid = 4'b0010; r0_data = 32'h0000_5500;
    tick();
    check("ng_ready", 32'(r0_ready), 32'd2);
    check("ng_send",  32'(t0_send),  32'd1);
    check("ng_data",  32'(t0_data),  32'h55);
    check("ng_gid",   32'(g0_id),    32'd1);
    repeat (3) begin
      busy0 = 1'b1;
      repeat (3) begin
        tick(); check("ng_quiet", 32'(t0_send), 32'd0);
      end
      busy0 = 1'b0;
      tick();
      check("ng_no_gap_send", 32'(t0_send), 32'd0);
      check("ng_idle",        32'(a0),      32'd0);
      tick();
      check("ng_resend", 32'(t0_send),  32'd1);
      check("ng_ready2", 32'(r0_ready), 32'd2);
    end
    busy0 = 1'b1;
    tick();
    r0_valid = '0;
    tick();
    busy0 = 1'b0;
    repeat (6) begin
      tick();
      check("ng_drop_ready", 32'(r0_ready), 32'd0);
      check("ng_drop_send",  32'(t0_send),  32'd0);
    end
    check("ng_err", 32'(e0), 32'd0);
    check("ng_state", 32'(s0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
